// File: rtl/rat_pkg.sv
// Shared RAT MCU constants for the return-address stack.
// Sizes and the COUNT-width helper used by the stack and its interface.
package rat_pkg;

  localparam int ADDR_W    = 10;
  localparam int RAS_DEPTH = 8;

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Control-unit <-> return-address-stack signal bundle.
// OVF/UNF are present only when RAS_ERR_EN is defined.
interface ret_addr_stack_if
  import rat_pkg::*;
#(
  parameter int n     = ADDR_W,
  parameter int DEPTH = RAS_DEPTH
);

  logic                     PUSH;
  logic                     POP;
  logic                     FLUSH;
  logic [n-1:0]             PC_IN;
  logic [n-1:0]             TOP;
  logic                     EMPTY;
  logic                     FULL;
  logic [cnt_w(DEPTH)-1:0]  COUNT;
`ifdef RAS_ERR_EN
  logic                     OVF;
  logic                     UNF;
`endif

  modport master (
    output PUSH, POP, FLUSH, PC_IN,
    input  TOP, EMPTY, FULL, COUNT
`ifdef RAS_ERR_EN
    , input OVF, UNF
`endif
  );

  modport slave (
    input  PUSH, POP, FLUSH, PC_IN,
    output TOP, EMPTY, FULL, COUNT
`ifdef RAS_ERR_EN
    , output OVF, UNF
`endif
  );

endinterface

// File: rtl/ras_regfile.sv
// Return-address storage: one sync write port, one async read port.
// Contents are intentionally not reset.
module ras_regfile #(
  parameter int n     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [n-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [n-1:0]             rdata
);

  logic [n-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack (LIFO) feeding the PC mux FROM_STACK input.
// Define RAS_ERR_EN to add sticky OVF/UNF flags.
module ret_addr_stack
  import rat_pkg::*;
#(
  parameter int n     = ADDR_W,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic            CLK,
  input  logic            RST_N,
  ret_addr_stack_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr, top_idx, waddr;
  logic [n-1:0]  nxt_pc, rdata;
  logic          we, empty, full;
  logic          push_pop, push_only, pop_only;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign wr_ptr    = cnt_q[PW-1:0];
  assign top_idx   = wr_ptr - PW'(1);
  assign nxt_pc    = bus.PC_IN + n'(1);
  assign push_pop  = bus.PUSH & bus.POP;
  assign push_only = bus.PUSH & ~bus.POP;
  assign pop_only  = bus.POP & ~bus.PUSH;

  always_comb begin
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = wr_ptr;
    if (bus.FLUSH) begin
      cnt_d = '0;
    end else begin
      unique case (1'b1)
        push_pop && !empty: begin
          we    = 1'b1;
          waddr = top_idx;
        end
        push_pop && empty: begin
          we    = 1'b1;
          cnt_d = CW'(1);
        end
        push_only && !full: begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
        pop_only && !empty: begin
          cnt_d = cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  ras_regfile #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_rf (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (nxt_pc),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign bus.TOP   = empty ? '0 : rdata;
  assign bus.EMPTY = empty;
  assign bus.FULL  = full;
  assign bus.COUNT = cnt_q;

`ifdef RAS_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A pop on an empty stack underflows whether or not a push rides along.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.FLUSH) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push_only && full) ovf_d = 1'b1;
      if (bus.POP && empty)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.OVF = ovf_q;
  assign bus.UNF = unf_q;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed plan plus random ops vs a queue model.
// Works with or without RAS_ERR_EN defined.
module tb_ret_addr_stack;
  import rat_pkg::*;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  logic [9:0] mdl[$];
  bit         m_ovf;
  bit         m_unf;

  ret_addr_stack_if bus ();

  ret_addr_stack dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_step(input bit p, input bit q, input bit f,
                          input logic [9:0] pc);
    logic [9:0] v;
    v = pc + 10'd1;
    if (f) begin
      mdl.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p && q) begin
      if (mdl.size() > 0) mdl[mdl.size()-1] = v;
      else begin
        mdl.push_back(v);
        m_unf = 1;
      end
    end else if (p) begin
      if (mdl.size() < RAS_DEPTH) mdl.push_back(v);
      else m_ovf = 1;
    end else if (q) begin
      if (mdl.size() > 0) void'(mdl.pop_back());
      else m_unf = 1;
    end
  endtask

  task automatic chk_all(input string tag);
    int sz;
    int top;
    sz  = mdl.size();
    top = (sz > 0) ? int'(mdl[sz-1]) : 0;
    chk({tag, ".top"},   int'(bus.TOP),   top);
    chk({tag, ".count"}, int'(bus.COUNT), sz);
    chk({tag, ".empty"}, int'(bus.EMPTY), int'(sz == 0));
    chk({tag, ".full"},  int'(bus.FULL),  int'(sz == RAS_DEPTH));
`ifdef RAS_ERR_EN
    chk({tag, ".ovf"},   int'(bus.OVF),   int'(m_ovf));
    chk({tag, ".unf"},   int'(bus.UNF),   int'(m_unf));
`endif
  endtask

  // Drive one strobe cycle, then check #1 after the edge.
  task automatic cyc(input bit p, input bit q, input bit f,
                     input logic [9:0] pc, input string tag);
    bus.PUSH  = p;
    bus.POP   = q;
    bus.FLUSH = f;
    bus.PC_IN = pc;
    @(posedge clk);
    mdl_step(p, q, f, pc);
    #1;
    bus.PUSH  = 0;
    bus.POP   = 0;
    bus.FLUSH = 0;
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 0;
    mdl.delete();
    m_ovf = 0;
    m_unf = 0;
    #1;
    chk_all("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    bus.PUSH  = 0;
    bus.POP   = 0;
    bus.FLUSH = 0;
    bus.PC_IN = '0;
    rst_n     = 1;
    #2;
    do_reset();

    cyc(1, 0, 0, 10'h0A4, "push1");
    chk("push1.top_k", int'(bus.TOP), 'h0A5);

    cyc(0, 0, 1, 10'h000, "flush0");
    cyc(1, 0, 0, 10'h010, "pA");
    cyc(1, 0, 0, 10'h020, "pB");
    cyc(1, 0, 0, 10'h030, "pC");
    chk("seq.top0", int'(bus.TOP), 'h031);
    cyc(0, 1, 0, 10'h000, "popA");
    chk("seq.top1", int'(bus.TOP), 'h021);
    cyc(0, 1, 0, 10'h000, "popB");
    chk("seq.top2", int'(bus.TOP), 'h011);
    cyc(0, 1, 0, 10'h000, "popC");
    chk("seq.top3", int'(bus.TOP), 'h000);
    chk("seq.empty", int'(bus.EMPTY), 1);

    for (int i = 0; i < 8; i++)
      cyc(1, 0, 0, 10'(10'h100 + i), "fill");
    cyc(1, 0, 0, 10'h200, "ovfpush");
    chk("ovf.top", int'(bus.TOP), 'h108);
    chk("ovf.count", int'(bus.COUNT), 8);
    cyc(1, 1, 0, 10'h055, "fullrep");
    chk("fullrep.top", int'(bus.TOP), 'h056);

    cyc(0, 0, 1, 10'h000, "flush1");
    cyc(0, 1, 0, 10'h000, "unfpop");
    chk("unf.top", int'(bus.TOP), 0);
    cyc(1, 1, 0, 10'h3FF, "emptypp");
    chk("wrap.top", int'(bus.TOP), 0);
    chk("wrap.count", int'(bus.COUNT), 1);

    cyc(1, 0, 0, 10'h040, "p3a");
    cyc(1, 0, 0, 10'h041, "p3b");
    cyc(1, 1, 0, 10'h055, "rep3");
    chk("rep3.top", int'(bus.TOP), 'h056);
    cyc(0, 1, 0, 10'h000, "rep3pop");
    chk("rep3.below", int'(bus.TOP), 'h041);

    cyc(0, 0, 1, 10'h000, "flush2");
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 0, 10'(10'h300 + i), "fill2");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 10'h000, "drain2");
    chk("c5.count", int'(bus.COUNT), 5);
    cyc(0, 0, 1, 10'h000, "flush5");
    chk("flush5.count", int'(bus.COUNT), 0);

    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 10'(10'h080 + i), "fill3");
    @(posedge clk);
    #3;
    rst_n = 0;
    mdl.delete();
    m_ovf = 0;
    m_unf = 0;
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      int         r;
      logic [9:0] pc;
      r  = int'($urandom_range(0, 31));
      pc = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
      if (r == 0)       cyc(0, 0, 1, pc, "rnd");
      else if (r < 13)  cyc(1, 0, 0, pc, "rnd");
      else if (r < 24)  cyc(0, 1, 0, pc, "rnd");
      else if (r < 29)  cyc(1, 1, 0, pc, "rnd");
      else              cyc(0, 0, 0, pc, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
